// File: rtl/cell_pkg.sv
// Shared types and helpers for the cell arbiter slice.
// Default widths match the standard 4-requester, 32-bit configuration.
package cell_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int MSB_DEF      = 31;
  localparam int CELL_LAT_DEF = 1;
  localparam int W_DEF        = MSB_DEF + 1;
  localparam int ID_W_DEF     = (N_REQ_DEF < 2) ? 1 : $clog2(N_REQ_DEF);

  typedef logic [W_DEF-1:0]    data_t;
  typedef logic [ID_W_DEF-1:0] tag_id_t;

  typedef struct packed {
    logic    valid;
    tag_id_t id;
  } tag_entry_t;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Modular increment for operands already below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/cell_arbiter_if.sv
// Requester/cell/response bundle of the cell arbiter.
// slave = arbiter side, master = requesters plus shared cell.
interface cell_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 32
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [W-1:0]       cell_data_in;
  logic               cell_data_en;
  logic [W-1:0]       cell_data_out;
  logic               cell_en_out;
  logic [W-1:0]       resp_data;
  logic [N_REQ-1:0]   resp_valid;
  logic               err;

  modport slave (
    input  req_valid, req_data, cell_data_out, cell_en_out,
    output req_ready, cell_data_in, cell_data_en, resp_data, resp_valid, err
  );

  modport master (
    output req_valid, req_data, cell_data_out, cell_en_out,
    input  req_ready, cell_data_in, cell_data_en, resp_data, resp_valid, err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at ptr, ptr+1, ...
// wrapping modulo N_REQ; returns one-hot grant and its index.
module rr_arbiter
  import cell_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  logic [ID_W-1:0]  cand [N_REQ];
  logic [N_REQ-1:0] rot;

  // rot[k] is the request that sits k positions after the pointer
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign cand[gi] = ID_W'(wrap_add(int'(ptr), gi, N_REQ));
      assign rot[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    grant     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_idx = cand[k];
        grant_any = 1'b1;
      end
    end
    if (grant_any) begin
      grant = N_REQ'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/cell_arbiter.sv
// Shares one fixed-latency cell among N_REQ requesters with tagged routing of results.
// Define CELL_ARB_ERR_EN to get a sticky err on tag/result misalignment.
module cell_arbiter
  import cell_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MSB      = MSB_DEF,
  parameter int CELL_LAT = CELL_LAT_DEF
) (
  input logic           clk,
  input logic           rst,
  cell_arbiter_if.slave bus
);

  localparam int W    = MSB + 1;
  localparam int ID_W = id_width(N_REQ);

  typedef logic [ID_W-1:0] id_t;
  typedef struct packed {
    logic valid;
    id_t  id;
  } tag_t;

  logic [N_REQ-1:0] grant;
  id_t              grant_idx;
  logic             grant_any;

  id_t              ptr_q, ptr_d;
  logic             cell_data_en_q, cell_data_en_d;
  logic [W-1:0]     cell_data_in_q, cell_data_in_d;
  id_t              issue_id_q, issue_id_d;
  tag_t             tag_q [CELL_LAT];
  tag_t             tag_d [CELL_LAT];
  tag_t             out_tag;
  logic             resp_hit;
  logic [W-1:0]     resp_data_q, resp_data_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grant is masked while reset is held so every output reads zero at once.
  assign bus.req_ready = rst ? '0 : grant;

  always_comb begin
    ptr_d          = ptr_q;
    cell_data_en_d = grant_any;
    cell_data_in_d = cell_data_in_q;
    issue_id_d     = issue_id_q;
    if (grant_any) begin
      ptr_d          = id_t'(wrap_add(int'(grant_idx), 1, N_REQ));
      cell_data_in_d = bus.req_data[int'(grant_idx)*W +: W];
      issue_id_d     = grant_idx;
    end
  end

  // Tag enters alongside the operand and walks CELL_LAT stages to meet cell_en_out.
  assign tag_d[0] = '{valid: cell_data_en_q, id: issue_id_q};
  generate
    for (genvar gi = 1; gi < CELL_LAT; gi++) begin : g_tag
      assign tag_d[gi] = tag_q[gi-1];
    end
  endgenerate
  assign out_tag = tag_q[CELL_LAT-1];

  assign resp_hit = bus.cell_en_out & out_tag.valid;

  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (resp_hit) begin
      resp_valid_d = N_REQ'(1) << out_tag.id;
      resp_data_d  = bus.cell_data_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      cell_data_en_q <= 1'b0;
      cell_data_in_q <= '0;
      issue_id_q     <= '0;
      resp_data_q    <= '0;
      resp_valid_q   <= '0;
      for (int k = 0; k < CELL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q          <= ptr_d;
      cell_data_en_q <= cell_data_en_d;
      cell_data_in_q <= cell_data_in_d;
      issue_id_q     <= issue_id_d;
      resp_data_q    <= resp_data_d;
      resp_valid_q   <= resp_valid_d;
      for (int k = 0; k < CELL_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign bus.cell_data_en = cell_data_en_q;
  assign bus.cell_data_in = cell_data_in_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;

`ifdef CELL_ARB_ERR_EN
  logic err_q, err_d;

  // Either a result with no tag or a tag with no result is a protocol fault.
  always_comb begin
    err_d = err_q | (bus.cell_en_out ^ out_tag.valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_cell_arbiter.sv
// Directed + random bench for cell_arbiter at CELL_LAT=1 and CELL_LAT=3,
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_cell_arbiter;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    int             dut;
    int             due;
    int             id;
    logic [W-1:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid_s;
  logic [N*W-1:0] req_data_s;
  logic           inject;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cell_arbiter_if #(.N_REQ(N), .W(W)) if0 ();
  cell_arbiter_if #(.N_REQ(N), .W(W)) if1 ();

  cell_arbiter #(.N_REQ(N), .MSB(W-1), .CELL_LAT(LAT0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  cell_arbiter #(.N_REQ(N), .MSB(W-1), .CELL_LAT(LAT1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  assign if0.req_valid = req_valid_s;
  assign if0.req_data  = req_data_s;
  assign if1.req_valid = req_valid_s;
  assign if1.req_data  = req_data_s;

  // Shared-cell models: result = operand + 2 after the configured latency.
  logic [W:0] cm0 [LAT0];
  logic [W:0] cm1 [LAT1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT0; k++) cm0[k] <= '0;
      for (int k = 0; k < LAT1; k++) cm1[k] <= '0;
    end else begin
      cm0[0] <= {if0.cell_data_en, if0.cell_data_in + 32'd2};
      for (int k = 1; k < LAT0; k++) cm0[k] <= cm0[k-1];
      cm1[0] <= {if1.cell_data_en, if1.cell_data_in + 32'd2};
      for (int k = 1; k < LAT1; k++) cm1[k] <= cm1[k-1];
    end
  end

  assign if0.cell_en_out   = cm0[LAT0-1][W] | inject;
  assign if0.cell_data_out = cm0[LAT0-1][W-1:0];
  assign if1.cell_en_out   = cm1[LAT1-1][W] | inject;
  assign if1.cell_data_out = cm1[LAT1-1][W-1:0];

  // Reference model state
  exp_t         expq[$];
  int           ptr_m     [2];
  int           lat_m     [2];
  logic         exp_cen   [2];
  logic [W-1:0] exp_cdin  [2];
  logic [W-1:0] exp_rdata [2];
  logic         exp_err   [2];
  logic [N-1:0] obs_ready0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    for (int d = 0; d < 2; d++) begin
      ptr_m[d]     = 0;
      exp_cen[d]   = 1'b0;
      exp_cdin[d]  = '0;
      exp_rdata[d] = '0;
      exp_err[d]   = 1'b0;
    end
  endtask

  task automatic check_dut(input int d, input logic [N-1:0] rdy, input logic cen,
                           input logic [W-1:0] cdin, input logic [N-1:0] rv,
                           input logic [W-1:0] rd, input logic e);
    int           g;
    int           hit;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [W-1:0] gdata;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && req_valid_s[(ptr_m[d] + k) % N]) g = (ptr_m[d] + k) % N;
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    chk($sformatf("dut%0d req_ready", d), W'(rdy), W'(exp_rdy));
    chk($sformatf("dut%0d cell_data_en", d), W'(cen), W'(exp_cen[d]));
    chk($sformatf("dut%0d cell_data_in", d), cdin, exp_cdin[d]);
    hit = -1;
    for (int i = 0; i < expq.size(); i++) begin
      if (hit < 0 && expq[i].dut == d) hit = i;
    end
    exp_rv = '0;
    if (hit >= 0 && expq[hit].due == cyc) begin
      exp_rv       = N'(1 << expq[hit].id);
      exp_rdata[d] = expq[hit].data;
      expq.delete(hit);
    end
    chk($sformatf("dut%0d resp_valid", d), W'(rv), W'(exp_rv));
    chk($sformatf("dut%0d resp_data", d), rd, exp_rdata[d]);
    chk($sformatf("dut%0d err", d), W'(e), W'(exp_err[d]));
`ifdef CELL_ARB_ERR_EN
    if (inject) exp_err[d] = 1'b1;
`endif
    if (g >= 0) begin
      gdata       = req_data_s[g*W +: W];
      exp_cen[d]  = 1'b1;
      exp_cdin[d] = gdata;
      expq.push_back('{dut: d, due: cyc + lat_m[d] + 2, id: g, data: gdata + 32'd2});
      ptr_m[d]    = (g + 1) % N;
    end else begin
      exp_cen[d] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    obs_ready0 = if0.req_ready;
    check_dut(0, if0.req_ready, if0.cell_data_en, if0.cell_data_in, if0.resp_valid, if0.resp_data, if0.err);
    check_dut(1, if1.req_ready, if1.cell_data_en, if1.cell_data_in, if1.resp_valid, if1.resp_data, if1.err);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, " dut0 ready"}, W'(if0.req_ready), '0);
    chk({tag, " dut0 cen"},   W'(if0.cell_data_en), '0);
    chk({tag, " dut0 cdin"},  if0.cell_data_in, '0);
    chk({tag, " dut0 rv"},    W'(if0.resp_valid), '0);
    chk({tag, " dut0 rd"},    if0.resp_data, '0);
    chk({tag, " dut0 err"},   W'(if0.err), '0);
    chk({tag, " dut1 ready"}, W'(if1.req_ready), '0);
    chk({tag, " dut1 cen"},   W'(if1.cell_data_en), '0);
    chk({tag, " dut1 rv"},    W'(if1.resp_valid), '0);
    chk({tag, " dut1 err"},   W'(if1.err), '0);
  endtask

  initial begin
    lat_m[0]    = LAT0;
    lat_m[1]    = LAT1;
    rst         = 1'b1;
    req_valid_s = '0;
    req_data_s  = '0;
    inject      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_outputs_check("por");
    rst = 1'b0;

    // idle: nothing granted, pointer left at 0
    repeat (2) cycle();

    // fairness: all four requesting for 8 cycles
    req_valid_s = '1;
    for (int i = 0; i < N; i++) req_data_s[i*W +: W] = 32'(100 + i);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("fair_order", W'(obs_ready0), W'(4'b0001 << (k % 4)));
    end

    // single requester 1 with operand 5 (result 7 three cycles later on dut0)
    req_valid_s = 4'b0010;
    req_data_s[1*W +: W] = 32'd5;
    cycle();
    req_valid_s = '0;
    repeat (6) cycle();

    // pipelining: pointer is at 2, four back-to-back grants 2,3,0,1
    req_valid_s = '1;
    for (int i = 0; i < N; i++) req_data_s[i*W +: W] = 32'(32'h1000 * (i + 1));
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("pipe_order", W'(obs_ready0), W'(4'b0001 << ((k + 2) % 4)));
    end
    req_valid_s = '0;
    repeat (8) cycle();

    // spurious cell_en_out with an empty tag pipe
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    repeat (3) cycle();

    // random traffic
    for (int k = 0; k < 300; k++) begin
      req_valid_s = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) req_data_s[i*W +: W] = $urandom;
      cycle();
    end

    // reset in the middle of traffic
    req_valid_s = '1;
    #2;
    rst = 1'b1;
    #1;
    reset_outputs_check("mid_rst");
    model_reset();
    req_valid_s = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) cycle();

    for (int k = 0; k < 150; k++) begin
      req_valid_s = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) req_data_s[i*W +: W] = $urandom;
      cycle();
    end
    req_valid_s = '0;
    repeat (8) cycle();
    chk("drain_empty", W'(expq.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
